balance_update: RTL and testbench

Account balance write-back engine for the ATM datapath. It stores the per-card balances and returns the new balance after a query, deposit or withdrawal. It is the writer side of the card lookup path: it accepts a committed transaction from the main FSM, checks the result, writes it to balance storage and reports status and the resulting balance.

---
 rtl/balance_update.sv | 230 +++++++++++++++++++++++
 tb/tb_balance_update.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/balance_update.sv
// balance_update: per-card balance store with a five-step
// lookup / compute / write / report sequence. Handles query, deposit and withdraw.
// A session end (card_out) aborts operations that have not reached the write step.
`timescale 1ns/1ps
module balance_update #(
  parameter int C_WIDTH = 6,
  parameter int B_WIDTH = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [C_WIDTH-1:0] card_number,
  input  logic               op_valid,
  input  logic [1:0]         op_type,
  input  logic [B_WIDTH-1:0] amount,
  input  logic               card_out,
  output logic               op_ready,
  output logic               done,
  output logic [1:0]         status,
  output logic [B_WIDTH-1:0] updated_balance
);

  localparam int N_ENTRY = 5;

  localparam logic [1:0] OP_QUERY = 2'b00;
  localparam logic [1:0] OP_DEP   = 2'b01;
  localparam logic [1:0] OP_WD    = 2'b10;
  localparam logic [1:0] OP_RSV   = 2'b11;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_INS = 2'b01;
  localparam logic [1:0] ST_OVF = 2'b10;
  localparam logic [1:0] ST_BAD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_COMPUTE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Card number owning each storage slot.
  function automatic logic [C_WIDTH-1:0] card_code(input int idx);
    case (idx)
      0:       return C_WIDTH'(6'b110001);
      1:       return C_WIDTH'(6'b111011);
      2:       return C_WIDTH'(6'b110011);
      3:       return C_WIDTH'(6'b111110);
      default: return C_WIDTH'(6'b000111);
    endcase
  endfunction

  // Balance each slot reloads on reset.
  function automatic logic [B_WIDTH-1:0] reset_val(input int idx);
    case (idx)
      0:       return B_WIDTH'(32'd2000);
      1:       return B_WIDTH'(32'd50000);
      2:       return B_WIDTH'(32'd100000);
      3:       return B_WIDTH'(32'd200000);
      default: return B_WIDTH'(32'd1000000);
    endcase
  endfunction

  state_t               r_state;
  state_t               w_next;
  logic                 w_accept;

  logic [C_WIDTH-1:0]   r_card;
  logic [1:0]           r_op;
  logic [B_WIDTH-1:0]   r_amount;

  logic                 w_hit;
  logic [2:0]           w_idx;
  logic [B_WIDTH-1:0]   w_old;
  logic                 r_hit;
  logic [2:0]           r_idx;
  logic [B_WIDTH-1:0]   r_old;

  logic [B_WIDTH:0]     w_sum;
  logic [1:0]           w_status;
  logic [B_WIDTH-1:0]   w_result;
  logic                 w_we;
  logic [1:0]           r_status_c;
  logic [B_WIDTH-1:0]   r_result;
  logic                 r_we;

  logic [B_WIDTH-1:0]   r_mem [N_ENTRY];

  logic                 r_done;
  logic [1:0]           r_status;
  logic [B_WIDTH-1:0]   r_upd;

  assign op_ready        = (r_state == S_IDLE) && !card_out;
  assign w_accept        = op_valid && op_ready;
  assign done            = r_done;
  assign status          = r_status;
  assign updated_balance = r_upd;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state: card_out aborts only before the write step, so commits are atomic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_LOOKUP;
      S_LOOKUP:  w_next = card_out ? S_IDLE : S_COMPUTE;
      S_COMPUTE: w_next = card_out ? S_IDLE : S_WRITE;
      S_WRITE:   w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Request capture; inputs are ignored for the rest of the operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_card   <= '0;
      r_op     <= OP_QUERY;
      r_amount <= '0;
    end else if (w_accept) begin
      r_card   <= card_number;
      r_op     <= op_type;
      r_amount <= amount;
    end
  end

  // Card decode and slot read mux.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    w_old = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      if (r_card == card_code(i)) begin
        w_hit = 1'b1;
        w_idx = 3'(i);
        w_old = r_mem[i];
      end
    end
  end

  // Lookup stage: latch decode result and old balance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit <= 1'b0;
      r_idx <= '0;
      r_old <= '0;
    end else if (r_state == S_LOOKUP) begin
      r_hit <= w_hit;
      r_idx <= w_idx;
      r_old <= w_old;
    end
  end

  assign w_sum = {1'b0, r_old} + {1'b0, r_amount};

  // Result evaluation; bad request outranks everything, then the op-specific checks.
  always_comb begin
    w_status = ST_OK;
    w_result = r_old;
    w_we     = 1'b0;
    if (!r_hit || r_op == OP_RSV) begin
      w_status = ST_BAD;
      w_result = '0;
    end else begin
      case (r_op)
        OP_DEP: begin
          if (w_sum[B_WIDTH]) begin
            w_status = ST_OVF;
          end else begin
            w_result = w_sum[B_WIDTH-1:0];
            w_we     = 1'b1;
          end
        end
        OP_WD: begin
          if (r_amount > r_old) begin
            w_status = ST_INS;
          end else begin
            w_result = r_old - r_amount;
            w_we     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Compute stage: hold result for the write and report steps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status_c <= ST_OK;
      r_result   <= '0;
      r_we       <= 1'b0;
    end else if (r_state == S_COMPUTE) begin
      r_status_c <= w_status;
      r_result   <= w_result;
      r_we       <= w_we;
    end
  end

  // Balance storage: reset reloads every slot; write only on a successful deposit/withdraw.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_ENTRY; i++) r_mem[i] <= reset_val(i);
    end else if (r_state == S_WRITE && r_we) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        if (r_idx == 3'(i)) r_mem[i] <= r_result;
      end
    end
  end

  // Report registers: updated on entry to DONE so they are valid with the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done   <= 1'b0;
      r_status <= ST_OK;
      r_upd    <= '0;
    end else begin
      r_done <= (r_state == S_WRITE);
      if (r_state == S_WRITE) begin
        r_status <= r_status_c;
        r_upd    <= r_result;
      end
    end
  end

endmodule

// File: tb/tb_balance_update.sv
// Bench for balance_update: directed scenarios plus random ops checked against
// an arithmetic model of the per-card balances.
`timescale 1ns/1ps
module tb_balance_update;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  card_number = '0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_type = '0;
  logic [19:0] amount = '0;
  logic        card_out = 1'b0;
  logic        op_ready;
  logic        done;
  logic [1:0]  status;
  logic [19:0] updated_balance;

  int total = 0;
  int bad = 0;
  longint model_bal [5];
  logic [5:0] cards [5] = '{6'b110001, 6'b111011, 6'b110011, 6'b111110, 6'b000111};

  always #5 clk = ~clk;

  balance_update #(.C_WIDTH(6), .B_WIDTH(20)) dut (
    .clk(clk), .rst(rst), .card_number(card_number), .op_valid(op_valid),
    .op_type(op_type), .amount(amount), .card_out(card_out), .op_ready(op_ready),
    .done(done), .status(status), .updated_balance(updated_balance)
  );

  function automatic int card_idx(input logic [5:0] c);
    for (int i = 0; i < 5; i++) if (cards[i] == c) return i;
    return -1;
  endfunction

  function automatic longint reset_bal(input int i);
    case (i)
      0: return 2000;
      1: return 50000;
      2: return 100000;
      3: return 200000;
      default: return 1000000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) model_bal[i] = reset_bal(i);
  endtask

  // Expected status/result of one committed op; updates the model on success.
  task automatic model_op(input logic [5:0] c, input logic [1:0] t, input longint a,
                          output logic [1:0] st, output logic [19:0] res);
    int k;
    longint old;
    k = card_idx(c);
    if (k < 0 || t == 2'b11) begin
      st = 2'b11; res = 20'd0;
      return;
    end
    old = model_bal[k];
    st = 2'b00; res = 20'(old);
    if (t == 2'b01) begin
      if (old + a > 1048575) st = 2'b10;
      else begin model_bal[k] = old + a; res = 20'(old + a); end
    end else if (t == 2'b10) begin
      if (a > old) st = 2'b01;
      else begin model_bal[k] = old - a; res = 20'(old - a); end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; op_valid = 1'b0; card_out = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Issue one op; card_out is raised in cycle co_cyc, rst lowered in cycle rst_cyc (0 = never).
  task automatic run_op(input logic [5:0] c, input logic [1:0] t, input logic [19:0] a,
                        input int co_cyc, input int rst_cyc,
                        output int dcyc, output int ndone, output logic [1:0] st,
                        output logic [19:0] bal, output logic [9:0] rdy, output logic [22:0] snap);
    int w;
    w = 0; dcyc = -1; ndone = 0; st = '0; bal = '0; rdy = '0; snap = '0;
    @(negedge clk);
    while (!op_ready && w < 20) begin @(negedge clk); w++; end
    total++;
    if (op_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_wait: op_ready=%b required 1", op_ready);
    end
    card_number = c; op_type = t; amount = a; op_valid = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      #1;
      if (cyc == 1) begin
        op_valid = 1'b0;
        card_number = 6'($urandom);
        op_type = 2'($urandom_range(0, 3));
        amount = 20'($urandom);
      end
      card_out = (cyc == co_cyc);
      rst = !(cyc == rst_cyc);
      @(negedge clk);
      rdy[cyc] = op_ready;
      if (cyc == rst_cyc) snap = {done, status, updated_balance};
      if (done === 1'b1) begin
        ndone++;
        if (dcyc < 0) begin dcyc = cyc; st = status; bal = updated_balance; end
      end
      @(posedge clk);
    end
    #1 card_out = 1'b0; rst = 1'b1;
  endtask

  // Normal op: checks done timing, single pulse, status and balance against the model.
  task automatic check_op(input string name, input logic [5:0] c, input logic [1:0] t,
                          input logic [19:0] a);
    int dcyc, nd;
    logic [1:0] st, est;
    logic [19:0] bal, eres;
    logic [9:0] rdy;
    logic [22:0] snap;
    run_op(c, t, a, 0, 0, dcyc, nd, st, bal, rdy, snap);
    model_op(c, t, longint'(a), est, eres);
    total++;
    if (dcyc !== 4 || nd !== 1 || st !== est || bal !== eres || rdy[5] !== 1'b1) begin
      bad++;
      $display("FAIL %s: card=%b op=%0d amt=%0d got done_cyc=%0d pulses=%0d st=%0d bal=%0d rdy5=%b required done_cyc=4 pulses=1 st=%0d bal=%0d rdy5=1",
               name, c, t, a, dcyc, nd, st, bal, rdy[5], est, eres);
    end
    $display("op %s card=%b type=%0d amt=%0d -> st=%0d bal=%0d done_cyc=%0d", name, c, t, a, st, bal, dcyc);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (done !== 1'b0 || status !== 2'b00 || updated_balance !== 20'd0 || op_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_outputs: done=%b st=%0d bal=%0d rdy=%b required 0 0 0 1",
               done, status, updated_balance, op_ready);
    end
    card_out = 1'b1; #1;
    total++;
    if (op_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_cardout: op_ready=%b required 0", op_ready);
    end
    card_out = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) check_op("reset_value", cards[i], 2'b00, 20'd0);
  endtask

  task automatic test_withdraw();
    do_reset();
    check_op("withdraw_ok", 6'b110001, 2'b10, 20'd500);
    total++;
    if (model_bal[0] !== 64'sd1500) begin
      bad++;
      $display("FAIL withdraw_model: model=%0d required 1500", model_bal[0]);
    end
    check_op("withdraw_query", 6'b110001, 2'b00, 20'd0);
  endtask

  task automatic test_insufficient();
    do_reset();
    check_op("withdraw_insuff", 6'b110001, 2'b10, 20'd2001);
    check_op("insuff_query", 6'b110001, 2'b00, 20'd0);
    check_op("withdraw_all", 6'b110001, 2'b10, 20'd2000);
  endtask

  task automatic test_overflow();
    do_reset();
    check_op("deposit_ovf", 6'b000111, 2'b01, 20'd48576);
    check_op("deposit_max", 6'b000111, 2'b01, 20'd48575);
    check_op("deposit_zero", 6'b000111, 2'b01, 20'd0);
    check_op("withdraw_zero", 6'b000111, 2'b10, 20'd0);
    check_op("max_query", 6'b000111, 2'b00, 20'd0);
  endtask

  task automatic test_bad_req();
    check_op("bad_card", 6'b101010, 2'b00, 20'd0);
    check_op("bad_op", 6'b111011, 2'b11, 20'd77);
    check_op("bad_op_query", 6'b111011, 2'b00, 20'd0);
  endtask

  task automatic test_abort();
    int dcyc, nd;
    logic [1:0] st;
    logic [19:0] bal;
    logic [9:0] rdy;
    logic [22:0] snap;
    do_reset();
    run_op(6'b110011, 2'b10, 20'd100, 2, 0, dcyc, nd, st, bal, rdy, snap);
    total++;
    if (nd !== 0 || rdy[3] !== 1'b1) begin
      bad++;
      $display("FAIL abort_compute: pulses=%0d rdy3=%b required pulses=0 rdy3=1", nd, rdy[3]);
    end
    $display("op abort_compute pulses=%0d rdy3=%b", nd, rdy[3]);
    check_op("abort_query", 6'b110011, 2'b00, 20'd0);
    run_op(6'b110011, 2'b10, 20'd100, 3, 0, dcyc, nd, st, bal, rdy, snap);
    total++;
    if (dcyc !== 4 || nd !== 1 || st !== 2'b00 || bal !== 20'd99900) begin
      bad++;
      $display("FAIL abort_in_write: done_cyc=%0d pulses=%0d st=%0d bal=%0d required 4 1 0 99900",
               dcyc, nd, st, bal);
    end
    $display("op abort_in_write done_cyc=%0d bal=%0d", dcyc, bal);
    model_bal[2] = 99900;
    check_op("write_query", 6'b110011, 2'b00, 20'd0);
  endtask

  task automatic test_blocked_accept();
    int nd;
    nd = 0;
    @(negedge clk);
    card_number = 6'b110011; op_type = 2'b10; amount = 20'd5; op_valid = 1'b1; card_out = 1'b1;
    #1;
    total++;
    if (op_ready !== 1'b0) begin
      bad++;
      $display("FAIL blocked_ready: op_ready=%b required 0", op_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    op_valid = 1'b0; card_out = 1'b0; #1;
    total++;
    if (nd !== 0 || op_ready !== 1'b1) begin
      bad++;
      $display("FAIL blocked_accept: pulses=%0d rdy=%b required 0 1", nd, op_ready);
    end
    $display("op blocked_accept pulses=%0d", nd);
    check_op("blocked_query", 6'b110011, 2'b00, 20'd0);
  endtask

  task automatic test_reset_mid();
    int dcyc, nd;
    logic [1:0] st;
    logic [19:0] bal;
    logic [9:0] rdy;
    logic [22:0] snap;
    check_op("pre_reset_dep", 6'b111110, 2'b01, 20'd7);
    run_op(6'b111110, 2'b01, 20'd1000, 0, 2, dcyc, nd, st, bal, rdy, snap);
    model_reset();
    total++;
    if (nd !== 0 || snap !== 23'd0) begin
      bad++;
      $display("FAIL reset_mid: pulses=%0d done/st/bal=%h required pulses=0 all zero", nd, snap);
    end
    $display("op reset_mid pulses=%0d snap=%h", nd, snap);
    check_op("reset_mid_query", 6'b111110, 2'b00, 20'd0);
  endtask

  task automatic test_random();
    logic [5:0] c;
    logic [1:0] t;
    logic [19:0] a;
    int k;
    for (int n = 0; n < 30; n++) begin
      k = int'($urandom_range(0, 5));
      c = (k < 5) ? cards[k] : 6'($urandom);
      t = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 1) == 0) ? 20'($urandom_range(0, 5000)) : 20'($urandom);
      check_op("random", c, t, a);
    end
  endtask

  task automatic test_back_to_back();
    int w, nd;
    int dcycs [3];
    logic [19:0] bals [3];
    logic [1:0] est;
    logic [19:0] eres;
    w = 0; nd = 0;
    @(negedge clk);
    while (!op_ready && w < 20) begin @(negedge clk); w++; end
    card_number = 6'b111011; op_type = 2'b01; amount = 20'd10; op_valid = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (nd < 3) begin dcycs[nd] = cyc; bals[nd] = updated_balance; end
        nd++;
      end
      if (cyc == 14) op_valid = 1'b0;
    end
    total++;
    if (nd !== 3) begin
      bad++;
      $display("FAIL b2b_count: pulses=%0d required 3", nd);
    end
    for (int j = 0; j < 3 && j < nd; j++) begin
      model_op(6'b111011, 2'b01, 10, est, eres);
      total++;
      if (dcycs[j] !== 4 + 5 * j || bals[j] !== eres) begin
        bad++;
        $display("FAIL b2b_op%0d: done_cyc=%0d bal=%0d required done_cyc=%0d bal=%0d",
                 j, dcycs[j], bals[j], 4 + 5 * j, eres);
      end
      $display("op b2b_%0d done_cyc=%0d bal=%0d", j, dcycs[j], bals[j]);
    end
    repeat (6) @(negedge clk);
    check_op("b2b_query", 6'b111011, 2'b00, 20'd0);
  endtask

  initial begin
    test_reset();
    test_withdraw();
    test_insufficient();
    test_overflow();
    test_bad_req();
    test_abort();
    test_blocked_accept();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
